sram_d_arbiter: RTL and testbench

SRAM_D_ARBITER -- requirements
Module: sram_d_arbiter

---
 rtl/sram_pkg.sv | 26 ++
 rtl/owner_fifo.sv | 75 +++++++
 rtl/sram_d_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_d_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared types and defaults for the SRAM data-port arbiter slice.
//            Holds the master-ID enum used to tag outstanding transactions
//            and the default depth of the response-owner FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

  // Master identifiers: core data port and wishbone/debug bridge.
  typedef enum logic {
    M_CORE   = 1'b0,
    M_BRIDGE = 1'b1
  } master_id_e;

  // Default number of outstanding responses the arbiter can track.
  localparam int unsigned c_rsp_depth_default = 2;

  // The master that is not 'id'; used to rotate the priority pointer.
  function automatic master_id_e other_master(input master_id_e id);
    return (id == M_CORE) ? M_BRIDGE : M_CORE;
  endfunction

endpackage : sram_pkg
`default_nettype wire

// File: rtl/owner_fifo.sv
`default_nettype none
// ============================================================================
// Module   : owner_fifo
// Purpose  : Small FIFO recording which master owns each outstanding SRAM
//            transaction, so responses can be routed back in order.
// Ports    : clk_i     - clock (rising edge)
//            rst_i     - synchronous active-high reset, empties the FIFO
//            push_i    - write push_id_i at the tail
//            push_id_i - owner of the transaction just accepted
//            pop_i     - drop the head entry
//            head_o    - owner at the head (valid when empty_o is low)
//            full_o    - no room for another entry
//            empty_o   - no entries held
// Revision : 1.0 - initial release
// ============================================================================
module owner_fifo
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH = c_rsp_depth_default
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  master_id_e push_id_i,
  input  logic       pop_i,
  output master_id_e head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w + 1)'(DEPTH);

  master_id_e         r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  logic w_push;
  logic w_pop;

  // Full/empty come from the separate count; pointers simply wrap because
  // DEPTH is a power of two.
  assign full_o  = (r_count == c_full_count);
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

  // Guard against misuse so the count can never over/underflow.
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_id_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : owner_fifo
`default_nettype wire

// File: rtl/sram_d_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_d_arbiter
// Purpose  : Two-master OBI arbiter in front of the SRAM data port. Muxes the
//            core data port (m0) and the wishbone/debug bridge (m1) onto one
//            SRAM request channel with zero added latency, and routes each
//            response back to the master that issued it.
// Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//            m*_req_i / m*_gnt_o   - master request handshake
//            m*_addr/we/be/wdata_i - master request fields
//            m*_rvalid/rdata_o     - master response
//            sram_d_*_o            - muxed request to the SRAM
//            sram_d_gnt/rvalid/rdata_i - SRAM grant and response
//            protocol_err_o        - sticky: response seen with no owner
// Revision : 1.0 - initial release
// ============================================================================
module sram_d_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = c_rsp_depth_default,
  parameter int unsigned FAIR_RR   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,

  output logic        sram_d_req_o,
  output logic [31:0] sram_d_addr_o,
  output logic        sram_d_we_o,
  output logic [3:0]  sram_d_be_o,
  output logic [31:0] sram_d_wdata_o,
  input  logic        sram_d_gnt_i,
  input  logic        sram_d_rvalid_i,
  input  logic [31:0] sram_d_rdata_i,

  output logic        protocol_err_o
);

  master_id_e r_prio;
  logic       r_protocol_err;

  master_id_e w_winner;
  logic       w_any_req;
  logic       w_accept;
  logic       w_rsp;
  master_id_e w_head;
  logic       w_full;
  logic       w_empty;

  // --------------------------------------------------------------------------
  // Winner selection: a lone requester always wins; on contention either the
  // rotating pointer or fixed m0 priority decides.
  // --------------------------------------------------------------------------
  always_comb begin
    w_winner = M_CORE;
    if (m0_req_i && m1_req_i) begin
      w_winner = (FAIR_RR != 0) ? r_prio : M_CORE;
    end else if (m1_req_i) begin
      w_winner = M_BRIDGE;
    end
  end

  assign w_any_req = m0_req_i || m1_req_i;

  // Requests are withheld while the owner FIFO is full so that every
  // accepted grant is guaranteed a slot for its owner tag.
  assign sram_d_req_o   = !rst_i && w_any_req && !w_full;
  assign sram_d_addr_o  = (w_winner == M_BRIDGE) ? m1_addr_i  : m0_addr_i;
  assign sram_d_we_o    = (w_winner == M_BRIDGE) ? m1_we_i    : m0_we_i;
  assign sram_d_be_o    = (w_winner == M_BRIDGE) ? m1_be_i    : m0_be_i;
  assign sram_d_wdata_o = (w_winner == M_BRIDGE) ? m1_wdata_i : m0_wdata_i;

  assign w_accept = sram_d_req_o && sram_d_gnt_i;
  assign m0_gnt_o = w_accept && (w_winner == M_CORE);
  assign m1_gnt_o = w_accept && (w_winner == M_BRIDGE);

  // --------------------------------------------------------------------------
  // Response routing: the head of the owner FIFO names the destination.
  // A response with nothing outstanding is dropped and flagged.
  // --------------------------------------------------------------------------
  assign w_rsp       = !rst_i && sram_d_rvalid_i && !w_empty;
  assign m0_rvalid_o = w_rsp && (w_head == M_CORE);
  assign m1_rvalid_o = w_rsp && (w_head == M_BRIDGE);
  assign m0_rdata_o  = m0_rvalid_o ? sram_d_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? sram_d_rdata_i : '0;

  assign protocol_err_o = r_protocol_err;

  owner_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_owner_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_accept),
    .push_id_i (w_winner),
    .pop_i     (w_rsp),
    .head_o    (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  // Priority pointer hands precedence to the master that just lost out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio <= M_CORE;
    end else if (w_accept) begin
      r_prio <= other_master(w_winner);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_protocol_err <= 1'b0;
    end else if (sram_d_rvalid_i && w_empty) begin
      r_protocol_err <= 1'b1;
    end
  end

endmodule : sram_d_arbiter
`default_nettype wire

// File: tb/tb_sram_d_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_d_arbiter
// Purpose  : Self-checking bench for sram_d_arbiter. Two instances share the
//            stimulus: round-robin (index 0) and fixed priority (index 1).
//            A queue-based model predicts every output each cycle; directed
//            scenarios add hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_d_arbiter;
  import sram_pkg::*;

  localparam int DEPTH = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic        m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        sram_d_gnt_i, sram_d_rvalid_i;
  logic [31:0] sram_d_rdata_i;

  logic [1:0]       sreq, swe, g0, g1, rv0, rv1, perr;
  logic [1:0][31:0] saddr, swd, rd0, rd1;
  logic [1:0][3:0]  sbe;

  sram_d_arbiter #(.RSP_DEPTH(DEPTH), .FAIR_RR(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(g0[0]), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(rv0[0]), .m0_rdata_o(rd0[0]),
    .m1_req_i(m1_req_i), .m1_gnt_o(g1[0]), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(rv1[0]), .m1_rdata_o(rd1[0]),
    .sram_d_req_o(sreq[0]), .sram_d_addr_o(saddr[0]), .sram_d_we_o(swe[0]),
    .sram_d_be_o(sbe[0]), .sram_d_wdata_o(swd[0]), .sram_d_gnt_i(sram_d_gnt_i),
    .sram_d_rvalid_i(sram_d_rvalid_i), .sram_d_rdata_i(sram_d_rdata_i),
    .protocol_err_o(perr[0])
  );

  sram_d_arbiter #(.RSP_DEPTH(DEPTH), .FAIR_RR(0)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(g0[1]), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(rv0[1]), .m0_rdata_o(rd0[1]),
    .m1_req_i(m1_req_i), .m1_gnt_o(g1[1]), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(rv1[1]), .m1_rdata_o(rd1[1]),
    .sram_d_req_o(sreq[1]), .sram_d_addr_o(saddr[1]), .sram_d_we_o(swe[1]),
    .sram_d_be_o(sbe[1]), .sram_d_wdata_o(swd[1]), .sram_d_gnt_i(sram_d_gnt_i),
    .sram_d_rvalid_i(sram_d_rvalid_i), .sram_d_rdata_i(sram_d_rdata_i),
    .protocol_err_o(perr[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: per instance, an ordered list of outstanding owners,
  // the master currently holding precedence, and the sticky error flag.
  // --------------------------------------------------------------------------
  int   mq   [2][8];
  int   mcnt [2];
  int   mprio[2];
  logic merr [2];

  always @(negedge clk_i) begin : p_cmp
    int   win, own;
    logic both, any, full, ereq, acc, rsp;
    for (int k = 0; k < 2; k++) begin
      if (rst_i) begin
        chk1($sformatf("i%0d_rst_req", k), sreq[k], 1'b0);
        chk1($sformatf("i%0d_rst_gnt0", k), g0[k], 1'b0);
        chk1($sformatf("i%0d_rst_gnt1", k), g1[k], 1'b0);
        chk1($sformatf("i%0d_rst_rv0", k), rv0[k], 1'b0);
        chk1($sformatf("i%0d_rst_rv1", k), rv1[k], 1'b0);
        chk32($sformatf("i%0d_rst_rd0", k), rd0[k], 32'h0);
        chk32($sformatf("i%0d_rst_rd1", k), rd1[k], 32'h0);
        mcnt[k]  = 0;
        mprio[k] = 0;
        merr[k]  = 1'b0;
      end else begin
        any  = m0_req_i || m1_req_i;
        both = m0_req_i && m1_req_i;
        if (both) win = (k == 0) ? mprio[k] : 0;
        else      win = m1_req_i ? 1 : 0;
        full = (mcnt[k] == DEPTH);
        ereq = any && !full;
        acc  = ereq && sram_d_gnt_i;
        rsp  = sram_d_rvalid_i && (mcnt[k] > 0);
        own  = mq[k][0];

        chk1($sformatf("i%0d_req", k), sreq[k], ereq);
        if (ereq) begin
          chk32($sformatf("i%0d_addr", k), saddr[k], (win == 1) ? m1_addr_i : m0_addr_i);
          chk1($sformatf("i%0d_we", k), swe[k], (win == 1) ? m1_we_i : m0_we_i);
          chk32($sformatf("i%0d_be", k), 32'(sbe[k]), 32'((win == 1) ? m1_be_i : m0_be_i));
          chk32($sformatf("i%0d_wdata", k), swd[k], (win == 1) ? m1_wdata_i : m0_wdata_i);
        end
        chk1($sformatf("i%0d_gnt0", k), g0[k], acc && (win == 0));
        chk1($sformatf("i%0d_gnt1", k), g1[k], acc && (win == 1));
        chk1($sformatf("i%0d_rv0", k), rv0[k], rsp && (own == 0));
        chk1($sformatf("i%0d_rv1", k), rv1[k], rsp && (own == 1));
        chk32($sformatf("i%0d_rd0", k), rd0[k], (rsp && own == 0) ? sram_d_rdata_i : 32'h0);
        chk32($sformatf("i%0d_rd1", k), rd1[k], (rsp && own == 1) ? sram_d_rdata_i : 32'h0);
        chk1($sformatf("i%0d_perr", k), perr[k], merr[k]);

        // Advance to the state after the coming rising edge.
        if (sram_d_rvalid_i && mcnt[k] == 0) merr[k] = 1'b1;
        if (rsp) begin
          for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
          mcnt[k]--;
        end
        if (acc) begin
          mq[k][mcnt[k]] = win;
          mcnt[k]++;
          mprio[k] = 1 - win;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the rising edge.
  // --------------------------------------------------------------------------
  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rst_i = 1'b0;
    m0_req_i = 1'b0; m1_req_i = 1'b0; m0_we_i = 1'b0; m1_we_i = 1'b0;
    m0_addr_i = '0; m1_addr_i = '0; m0_wdata_i = '0; m1_wdata_i = '0;
    m0_be_i = 4'hF; m1_be_i = 4'hF;
    sram_d_gnt_i = 1'b0; sram_d_rvalid_i = 1'b0; sram_d_rdata_i = '0;
  endtask

  task automatic do_reset();
    next_cyc();
    idle();
    rst_i = 1'b1;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    repeat (2) next_cyc();

    // Reset holds outputs low even with every input asserted.
    m0_req_i = 1'b1; m1_req_i = 1'b1; sram_d_gnt_i = 1'b1;
    sram_d_rvalid_i = 1'b1; sram_d_rdata_i = 32'hFFFF_FFFF;
    #1;
    chk1("lit_rst_req", sreq[0], 1'b0);
    chk1("lit_rst_gnt0", g0[0], 1'b0);
    chk1("lit_rst_rv0", rv0[0], 1'b0);
    chk32("lit_rst_rd1", rd1[0], 32'h0);

    // Spurious response right after reset sets the sticky error.
    next_cyc(); idle(); sram_d_rvalid_i = 1'b1; sram_d_rdata_i = 32'h0000_DEAD; #1;
    chk1("lit_spur_rv0", rv0[0], 1'b0);
    chk1("lit_spur_rv1", rv1[0], 1'b0);
    chk1("lit_spur_perr_pre", perr[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      next_cyc(); idle(); #1;
      chk1("lit_spur_perr_sticky", perr[0], 1'b1);
    end
    do_reset();
    next_cyc(); idle(); #1;
    chk1("lit_perr_cleared", perr[0], 1'b0);

    // Reset mid-transaction discards the outstanding owner.
    next_cyc(); idle(); m0_req_i = 1'b1; sram_d_gnt_i = 1'b1; #1;
    chk1("lit_mid_gnt", g0[0], 1'b1);
    next_cyc(); idle(); rst_i = 1'b1;
    next_cyc(); idle(); sram_d_rvalid_i = 1'b1; sram_d_rdata_i = 32'h1234; #1;
    chk1("lit_mid_rv0", rv0[0], 1'b0);
    next_cyc(); idle(); #1;
    chk1("lit_mid_perr", perr[0], 1'b1);
    do_reset();

    // Single master read.
    next_cyc(); idle(); m0_req_i = 1'b1; m0_addr_i = 32'h8000_0010; sram_d_gnt_i = 1'b1; #1;
    chk1("lit_single_req", sreq[0], 1'b1);
    chk1("lit_single_gnt0", g0[0], 1'b1);
    chk1("lit_single_gnt1", g1[0], 1'b0);
    chk32("lit_single_addr", saddr[0], 32'h8000_0010);
    next_cyc(); idle(); sram_d_rvalid_i = 1'b1; sram_d_rdata_i = 32'hCAFE_F00D; #1;
    chk1("lit_single_rv0", rv0[0], 1'b1);
    chk32("lit_single_rd0", rd0[0], 32'hCAFE_F00D);
    chk1("lit_single_rv1", rv1[0], 1'b0);
    chk32("lit_single_rd1", rd1[0], 32'h0);
    do_reset();

    // Contention: round-robin alternates, fixed priority always picks m0.
    for (int k = 0; k < 4; k++) begin
      next_cyc(); idle();
      m0_req_i = 1'b1; m0_addr_i = 32'h100; m1_req_i = 1'b1; m1_addr_i = 32'h200;
      sram_d_gnt_i = 1'b1; sram_d_rvalid_i = (k >= 1); sram_d_rdata_i = 32'hA0 + k;
      #1;
      chk1("lit_rr_gnt0", g0[0], (k % 2) == 0);
      chk1("lit_rr_gnt1", g1[0], (k % 2) == 1);
      chk1("lit_fp_gnt0", g0[1], 1'b1);
      chk1("lit_fp_gnt1", g1[1], 1'b0);
      if (k >= 1) begin
        chk1("lit_rr_rv0", rv0[0], ((k - 1) % 2) == 0);
        chk1("lit_rr_rv1", rv1[0], ((k - 1) % 2) == 1);
      end
    end
    next_cyc(); idle(); sram_d_rvalid_i = 1'b1; #1;
    chk1("lit_rr_last_rv1", rv1[0], 1'b1);
    do_reset();

    // Stalled SRAM: two grants fill the FIFO, requests stop until a pop.
    for (int k = 0; k < 2; k++) begin
      next_cyc(); idle(); m0_req_i = 1'b1; sram_d_gnt_i = 1'b1; #1;
      chk1("lit_stall_fill_gnt", g0[0], 1'b1);
    end
    next_cyc(); idle(); m0_req_i = 1'b1; sram_d_gnt_i = 1'b1; #1;
    chk1("lit_stall_req", sreq[0], 1'b0);
    chk1("lit_stall_gnt", g0[0], 1'b0);
    next_cyc(); idle(); m0_req_i = 1'b1; sram_d_gnt_i = 1'b1;
    sram_d_rvalid_i = 1'b1; sram_d_rdata_i = 32'h55; #1;
    chk1("lit_stall_pop_req", sreq[0], 1'b0);
    chk32("lit_stall_pop_rd0", rd0[0], 32'h55);
    next_cyc(); idle(); m0_req_i = 1'b1; sram_d_gnt_i = 1'b1; #1;
    chk1("lit_stall_resume", g0[0], 1'b1);
    repeat (2) begin
      next_cyc(); idle(); sram_d_rvalid_i = 1'b1;
    end
    do_reset();

    // Back-to-back write then read from m1.
    next_cyc(); idle();
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h8000_0004;
    m1_wdata_i = 32'h1234_5678; sram_d_gnt_i = 1'b1; #1;
    chk1("lit_b2b_wgnt", g1[0], 1'b1);
    chk1("lit_b2b_we", swe[0], 1'b1);
    chk32("lit_b2b_wdata", swd[0], 32'h1234_5678);
    next_cyc(); idle();
    m1_req_i = 1'b1; m1_addr_i = 32'h8000_0004; sram_d_gnt_i = 1'b1; sram_d_rvalid_i = 1'b1; #1;
    chk1("lit_b2b_rgnt", g1[0], 1'b1);
    chk1("lit_b2b_re", swe[0], 1'b0);
    chk1("lit_b2b_wack", rv1[0], 1'b1);
    next_cyc(); idle(); sram_d_rvalid_i = 1'b1; sram_d_rdata_i = 32'h1234_5678; #1;
    chk1("lit_b2b_rv1", rv1[0], 1'b1);
    chk32("lit_b2b_rd1", rd1[0], 32'h1234_5678);
    do_reset();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      next_cyc();
      rst_i          = ($urandom_range(0, 99) == 0);
      m0_req_i       = $urandom_range(0, 1);
      m1_req_i       = $urandom_range(0, 1);
      m0_addr_i      = $urandom;
      m1_addr_i      = $urandom;
      m0_we_i        = $urandom_range(0, 1);
      m1_we_i        = $urandom_range(0, 1);
      m0_be_i        = 4'($urandom);
      m1_be_i        = 4'($urandom);
      m0_wdata_i     = $urandom;
      m1_wdata_i     = $urandom;
      sram_d_gnt_i   = ($urandom_range(0, 3) != 0);
      sram_d_rvalid_i = (mcnt[0] > 0) ? ($urandom_range(0, 2) != 0)
                                      : ($urandom_range(0, 39) == 0);
      sram_d_rdata_i = $urandom;
    end
    next_cyc(); idle();
    repeat (3) next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_sram_d_arbiter
`default_nettype wire
